// File: rtl/mrc_ec_pkg.sv
// Shared constants for the skip-digit-6 error-check stage: sign encoding,
// digit-6 modulus and the fault FSM state type.
package mrc_ec_pkg;

  localparam logic [1:0] SGN_POS = 2'b00;
  localparam logic [1:0] SGN_NEG = 2'b01;
  localparam logic [1:0] SGN_AMB = 2'b10;
  localparam logic [1:0] SGN_RSV = 2'b11;

  localparam int unsigned D6_MODULUS = 262051;

  typedef enum logic [1:0] {
    EC_OK      = 2'd0,
    EC_SUSPECT = 2'd1,
    EC_FAULT   = 2'd2
  } ec_state_t;

  // Disagreeing or reserved sign inputs collapse to ambiguous.
  function automatic logic [1:0] sgn_resolve(input logic [1:0] a, input logic [1:0] b);
    if (a == SGN_RSV || b == SGN_RSV) return SGN_AMB;
    if (a == b)                       return a;
    return SGN_AMB;
  endfunction

endpackage

// File: rtl/mrc_valid_delay.sv
// Fixed-depth shift register with synchronous clear; carries {valid, digit}
// alongside the MRC pipe so both reach the checker in the same cycle.
module mrc_valid_delay #(
  parameter int DEPTH = 24,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] dly_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dly_pipe[i] <= '0;
    end else begin
      dly_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign q = dly_pipe[DEPTH-1];

endmodule

// File: rtl/mrc_skp6_ec_check.sv
// Digit-6 error check / resolve stage behind the skip-6 MRC pipe.
// Optional saturating mismatch counter: define MRC_EC_ERRCNT_EN.
module mrc_skp6_ec_check
  import mrc_ec_pkg::*;
#(
  parameter int PIPE_LAT   = 24,
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = D6_MODULUS,
  parameter int GOOD_RUN   = 4,
  parameter int FAULT_THR  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] dig6_rx,
  input  logic [DATA_WIDTH-1:0] d6_calc,
  input  logic [1:0]            sgn_a,
  input  logic [1:0]            sgn_b,
  input  logic                  fault_clr,
  output logic                  out_valid,
  output logic [1:0]            sign_out,
  output logic [DATA_WIDTH-1:0] dig6_out,
  output logic                  err_flag,
  output logic                  fault,
  output logic [1:0]            ec_state
`ifdef MRC_EC_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  localparam logic [DATA_WIDTH:0] MOD_W = (DATA_WIDTH+1)'(MODULUS);
  localparam logic [15:0]         THR_W = 16'(FAULT_THR);
  localparam logic [15:0]         RUN_W = 16'(GOOD_RUN);

  // Alignment of the received digit with the reconstructed one
  logic [DATA_WIDTH:0]   dly_in, dly_out;
  logic                  v_al;
  logic [DATA_WIDTH-1:0] rx_al;

  assign dly_in = {in_valid, dig6_rx};

  mrc_valid_delay #(.DEPTH(PIPE_LAT), .W(DATA_WIDTH+1)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dly_in),
    .q     (dly_out)
  );

  assign v_al  = dly_out[DATA_WIDTH];
  assign rx_al = dly_out[DATA_WIDTH-1:0];

  // Stage 1: compare, range check, sign resolve
  logic                  s1_v, s1_mis, s1_rerr;
  logic [1:0]            s1_sgn;
  logic [DATA_WIDTH-1:0] s1_calc, s1_rx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_mis  <= 1'b0;
      s1_rerr <= 1'b0;
      s1_sgn  <= SGN_POS;
      s1_calc <= '0;
      s1_rx   <= '0;
    end else begin
      s1_v <= v_al;
      if (v_al) begin
        s1_mis  <= (d6_calc != rx_al);
        s1_rerr <= ({1'b0, d6_calc} >= MOD_W) || ({1'b0, rx_al} >= MOD_W);
        s1_sgn  <= sgn_resolve(sgn_a, sgn_b);
        s1_calc <= d6_calc;
        s1_rx   <= rx_al;
      end
    end
  end

  // Stage 2: corrected outputs, held across idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dig6_out  <= '0;
      err_flag  <= 1'b0;
      sign_out  <= SGN_POS;
    end else begin
      out_valid <= s1_v;
      if (s1_v) begin
        dig6_out <= s1_mis ? s1_calc : s1_rx;
        err_flag <= s1_mis | s1_rerr;
        sign_out <= s1_sgn;
      end
    end
  end

  // Fault FSM, fed by the registered stage-2 sample
  ec_state_t   state, state_nx;
  logic [15:0] mcnt, mcnt_nx, gcnt, gcnt_nx;
  logic        bad;

  assign bad = err_flag | (sign_out == SGN_AMB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EC_OK;
      mcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mcnt_nx  = mcnt;
    gcnt_nx  = gcnt;
    case (state)
      EC_OK: begin
        if (out_valid && bad) begin
          state_nx = EC_SUSPECT;
          mcnt_nx  = 16'd1;
          gcnt_nx  = '0;
        end
      end
      EC_SUSPECT: begin
        if (out_valid) begin
          if (bad) begin
            gcnt_nx = '0;
            mcnt_nx = mcnt + 16'd1;
            if (mcnt_nx >= THR_W) state_nx = EC_FAULT;
          end else begin
            gcnt_nx = gcnt + 16'd1;
            if (gcnt_nx >= RUN_W) begin
              state_nx = EC_OK;
              mcnt_nx  = '0;
              gcnt_nx  = '0;
            end
          end
        end
      end
      EC_FAULT: begin
        // Clearing onto a bad sample restarts the burst count at one
        if (fault_clr) begin
          if (out_valid && bad) begin
            state_nx = EC_SUSPECT;
            mcnt_nx  = 16'd1;
          end else begin
            state_nx = EC_OK;
            mcnt_nx  = '0;
          end
          gcnt_nx = '0;
        end
      end
      default: begin
        state_nx = EC_OK;
        mcnt_nx  = '0;
        gcnt_nx  = '0;
      end
    endcase
  end

  always_comb begin
    fault    = (state == EC_FAULT);
    ec_state = state;
  end

`ifdef MRC_EC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if (out_valid && err_flag && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mrc_skp6_ec_check.sv
// Directed bench for mrc_skp6_ec_check: table-driven phases with aligned
// d6_calc/sign injection, hand-computed expected outputs and FSM states.
module tb_mrc_skp6_ec_check;

  localparam int L = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        fault_clr = 1'b0;
  logic [17:0] dig6_rx = '0;
  logic [17:0] d6_calc = '0;
  logic [1:0]  sgn_a = '0;
  logic [1:0]  sgn_b = '0;
  logic        out_valid, err_flag, fault;
  logic [1:0]  sign_out, ec_state;
  logic [17:0] dig6_out;
`ifdef MRC_EC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  mrc_skp6_ec_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dig6_rx   (dig6_rx),
    .d6_calc   (d6_calc),
    .sgn_a     (sgn_a),
    .sgn_b     (sgn_b),
    .fault_clr (fault_clr),
    .out_valid (out_valid),
    .sign_out  (sign_out),
    .dig6_out  (dig6_out),
    .err_flag  (err_flag),
    .fault     (fault),
    .ec_state  (ec_state)
`ifdef MRC_EC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Phase table
  int n;
  bit t_v [64];
  int t_rx [64], t_calc [64], t_sa [64], t_sb [64], t_clr [64];
  int e_dig [64], e_err [64], e_sgn [64], e_st [64];

  task automatic add(input bit v, input int rx, input int calc, input int sa, input int sb,
                     input int clr, input int edig, input int eerr, input int esgn, input int est);
    t_v[n] = v; t_rx[n] = rx; t_calc[n] = calc; t_sa[n] = sa; t_sb[n] = sb; t_clr[n] = clr;
    e_dig[n] = edig; e_err[n] = eerr; e_sgn[n] = esgn; e_st[n] = est;
    n++;
  endtask

  // Sample k enters at drive step k; d6_calc/sign at step k+L; outputs
  // observed at step k+L+2; FSM state at step k+L+3.
  task automatic run_phase(input string name);
    for (int k = 0; k <= n + L + 3; k++) begin
      int s, s2, c;
      @(negedge clk);
      s = k - L - 2;
      s2 = k - L - 3;
      c = k - L;
      if (s >= 0 && s < n) begin
        check($sformatf("%s[%0d].out_valid", name, s), out_valid, t_v[s]);
        check($sformatf("%s[%0d].dig6_out", name, s), dig6_out, e_dig[s]);
        check($sformatf("%s[%0d].err_flag", name, s), err_flag, e_err[s]);
        check($sformatf("%s[%0d].sign_out", name, s), sign_out, e_sgn[s]);
      end else begin
        check($sformatf("%s.idle_out_valid@%0d", name, k), out_valid, 0);
      end
      if (s2 >= 0 && s2 < n) begin
        check($sformatf("%s[%0d].ec_state", name, s2), ec_state, e_st[s2]);
        check($sformatf("%s[%0d].fault", name, s2), fault, (e_st[s2] == 2) ? 1 : 0);
      end
      in_valid = (k < n) ? t_v[k] : 1'b0;
      dig6_rx  = (k < n) ? 18'(t_rx[k]) : '0;
      if (c >= 0 && c < n) begin
        d6_calc = 18'(t_calc[c]);
        sgn_a   = 2'(t_sa[c]);
        sgn_b   = 2'(t_sb[c]);
      end else begin
        d6_calc = '0;
        sgn_a   = '0;
        sgn_b   = '0;
      end
      fault_clr = (s >= 0 && s < n) ? t_clr[s][0] : 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.dig6_out", dig6_out, 0);
    check("rst.err_flag", err_flag, 0);
    check("rst.sign_out", sign_out, 0);
    check("rst.ec_state", ec_state, 0);
    check("rst.fault", fault, 0);
`ifdef MRC_EC_ERRCNT_EN
    check("rst.err_count", err_count, 0);
`endif
    rst_n = 1'b1;

    // P1: clean stream with two idle gaps
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 10 || i == 20) add(0, 12345, 999, 0, 0, 0, 1000, 0, 0, 0);
      else                    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 0);
    end
    run_phase("clean");

    // P2: single mismatch, then recovery after four clean samples
    n = 0;
    add(1, 5, 7, 0, 0, 0, 7, 1, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 0);
    run_phase("mis1");

    // P3: burst into FAULT, sticky, clears with clean and with bad sample
    n = 0;
    add(1, 5, 7, 0, 0, 0, 7, 1, 0, 1);
    add(1, 6, 9, 0, 0, 0, 9, 1, 0, 1);
    add(1, 1, 2, 0, 0, 0, 2, 1, 0, 2);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 2);
    add(1, 1000, 1000, 0, 0, 1, 1000, 0, 0, 0);
    add(1, 3, 4, 0, 0, 0, 4, 1, 0, 1);
    add(1, 3, 4, 0, 0, 1, 4, 1, 0, 1);
    add(1, 3, 4, 0, 0, 0, 4, 1, 0, 2);
    add(1, 3, 4, 0, 0, 1, 4, 1, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 0);
    add(1, 1000, 1000, 0, 0, 1, 1000, 0, 0, 0);
    run_phase("fault");

    // P4: sign resolution
    n = 0;
    add(1, 1000, 1000, 1, 0, 0, 1000, 0, 2, 1);
    add(1, 1000, 1000, 3, 3, 0, 1000, 0, 2, 1);
    add(1, 1000, 1000, 1, 1, 0, 1000, 0, 1, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 1, 1, 0, 1000, 0, 1, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 0);
    add(1, 1000, 1000, 0, 3, 0, 1000, 0, 2, 1);
    add(1, 1000, 1000, 2, 2, 0, 1000, 0, 2, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 1);
    add(1, 1000, 1000, 0, 0, 0, 1000, 0, 0, 0);
    run_phase("sign");

    // P5: range check at and beyond the modulus
    n = 0;
    add(1, 262051, 262051, 0, 0, 0, 262051, 1, 0, 1);
    add(1, 262050, 262050, 0, 0, 0, 262050, 0, 0, 1);
    add(0, 77, 99, 0, 0, 0, 262050, 0, 0, 1);
    add(1, 262143, 262143, 0, 0, 0, 262143, 1, 0, 1);
    add(1, 262050, 262050, 0, 0, 0, 262050, 0, 0, 1);
    add(1, 262050, 262050, 0, 0, 0, 262050, 0, 0, 1);
    add(1, 262050, 262050, 0, 0, 0, 262050, 0, 0, 1);
    add(1, 262050, 262050, 0, 0, 0, 262050, 0, 0, 0);
    run_phase("range");

`ifdef MRC_EC_ERRCNT_EN
    // Counter saturation: continuous mismatches beyond 0xFFFF
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      in_valid = 1'b1; dig6_rx = 18'd0; d6_calc = 18'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (L + 5) @(negedge clk);
    check("sat.err_count", err_count, 32'hFFFF);
`endif

    // Mid-stream reset drops in-flight samples
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      in_valid = 1'b1; dig6_rx = 18'd5; d6_calc = 18'd7; sgn_a = 2'b00; sgn_b = 2'b00;
    end
    @(negedge clk);
    check("mid.fault_before_rst", fault, 1);
    check("mid.out_valid_before_rst", out_valid, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid.rst.out_valid", out_valid, 0);
    check("mid.rst.dig6_out", dig6_out, 0);
    check("mid.rst.err_flag", err_flag, 0);
    check("mid.rst.ec_state", ec_state, 0);
    check("mid.rst.fault", fault, 0);
`ifdef MRC_EC_ERRCNT_EN
    check("mid.rst.err_count", err_count, 0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clk);
      check($sformatf("mid.no_out_valid@%0d", k), out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
